// File: rtl/accumu_counter_pkg.sv
// rtl/accumu_counter_pkg.sv - shared defaults and count type for the event counter
package accumu_counter_pkg;

  localparam int CNT_W        = 3;
  localparam int CNT_ROLLOVER = 2;

  typedef logic [CNT_W-1:0] count_t;

endpackage

// File: rtl/accumu_counter.sv
// rtl/accumu_counter.sv - clearable up-counter with registered rollover flag
// Counts enabled cycles 1..ROLLOVER_VAL and flags the terminal value.
module accumu_counter
  import accumu_counter_pkg::*;
#(
  parameter int NUM_CNT_BITS = CNT_W,
  parameter int ROLLOVER_VAL = CNT_ROLLOVER
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  localparam logic [NUM_CNT_BITS-1:0] ROLL_VAL = NUM_CNT_BITS'(ROLLOVER_VAL);
  localparam logic [NUM_CNT_BITS-1:0] ONE      = NUM_CNT_BITS'(1);

  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic                    flag_q, flag_d;

  // Flag is derived from the next count so it rises together with count_out.
  always_comb begin
    count_d = count_q;
    flag_d  = flag_q;
    if (clear) begin
      count_d = '0;
      flag_d  = 1'b0;
    end else if (count_enable) begin
      if (count_q == ROLL_VAL) begin
        count_d = ONE;
      end else begin
        count_d = count_q + ONE;
      end
      flag_d = (count_d == ROLL_VAL);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
    end
  end

  assign count_out     = count_q;
  assign rollover_flag = flag_q;

endmodule

// File: tb/tb_accumu_counter.sv
// tb/tb_accumu_counter.sv - directed self-checking bench for accumu_counter
module tb_accumu_counter;
  import accumu_counter_pkg::*;

  logic   clk;
  logic   n_rst;
  logic   clear;
  logic   count_enable;
  count_t count_out;
  logic   rollover_flag;

  int errors = 0;
  int checks = 0;

  accumu_counter #(.NUM_CNT_BITS(3), .ROLLOVER_VAL(2)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .count_enable (count_enable),
    .count_out    (count_out),
    .rollover_flag(rollover_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b1; clear = 1'b0; count_enable = 1'b0;
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if (count_out !== 3'd0) begin errors++; $display("FAIL reset_en0_count: got %0d want 0", count_out); end
    checks++;
    if (rollover_flag !== 1'b0) begin errors++; $display("FAIL reset_en0_flag: got %b want 0", rollover_flag); end
    count_enable = 1'b1;
    #1;
    checks++;
    if (count_out !== 3'd0) begin errors++; $display("FAIL reset_en1_count: got %0d want 0", count_out); end
    checks++;
    if (rollover_flag !== 1'b0) begin errors++; $display("FAIL reset_en1_flag: got %b want 0", rollover_flag); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (count_out !== 3'd0) begin errors++; $display("FAIL reset_hold_count[%0d]: got %0d want 0", i, count_out); end
      checks++;
      if (rollover_flag !== 1'b0) begin errors++; $display("FAIL reset_hold_flag[%0d]: got %b want 0", i, rollover_flag); end
    end
  endtask

  task automatic test_count();
    @(negedge clk);
    n_rst = 1'b1; clear = 1'b0; count_enable = 1'b1;
    tick();
    checks++;
    if (count_out !== 3'd1) begin errors++; $display("FAIL count_first: got %0d want 1", count_out); end
    checks++;
    if (rollover_flag !== 1'b0) begin errors++; $display("FAIL count_first_flag: got %b want 0", rollover_flag); end
    tick();
    checks++;
    if (count_out !== 3'd2) begin errors++; $display("FAIL count_second: got %0d want 2", count_out); end
    checks++;
    if (rollover_flag !== 1'b1) begin errors++; $display("FAIL count_second_flag: got %b want 1", rollover_flag); end
  endtask

  task automatic test_wrap();
    tick();
    checks++;
    if (count_out !== 3'd1) begin errors++; $display("FAIL wrap_count: got %0d want 1", count_out); end
    checks++;
    if (rollover_flag !== 1'b0) begin errors++; $display("FAIL wrap_flag: got %b want 0", rollover_flag); end
    tick();
    checks++;
    if (count_out !== 3'd2) begin errors++; $display("FAIL wrap_next_count: got %0d want 2", count_out); end
    checks++;
    if (rollover_flag !== 1'b1) begin errors++; $display("FAIL wrap_next_flag: got %b want 1", rollover_flag); end
  endtask

  task automatic test_hold();
    @(negedge clk);
    count_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (count_out !== 3'd2) begin errors++; $display("FAIL hold_count[%0d]: got %0d want 2", i, count_out); end
      checks++;
      if (rollover_flag !== 1'b1) begin errors++; $display("FAIL hold_flag[%0d]: got %b want 1", i, rollover_flag); end
    end
  endtask

  task automatic test_clear_priority();
    @(negedge clk);
    clear = 1'b1; count_enable = 1'b1;
    tick();
    checks++;
    if (count_out !== 3'd0) begin errors++; $display("FAIL clear_count: got %0d want 0", count_out); end
    checks++;
    if (rollover_flag !== 1'b0) begin errors++; $display("FAIL clear_flag: got %b want 0", rollover_flag); end
    @(negedge clk);
    clear = 1'b0;
    tick();
    checks++;
    if (count_out !== 3'd1) begin errors++; $display("FAIL post_clear_count: got %0d want 1", count_out); end
    checks++;
    if (rollover_flag !== 1'b0) begin errors++; $display("FAIL post_clear_flag: got %b want 0", rollover_flag); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if (count_out !== 3'd0) begin errors++; $display("FAIL async_rst_count: got %0d want 0", count_out); end
    checks++;
    if (rollover_flag !== 1'b0) begin errors++; $display("FAIL async_rst_flag: got %b want 0", rollover_flag); end
    @(negedge clk);
    n_rst = 1'b1; count_enable = 1'b1;
    tick();
    checks++;
    if (count_out !== 3'd1) begin errors++; $display("FAIL after_rst_count: got %0d want 1", count_out); end
    checks++;
    if (rollover_flag !== 1'b0) begin errors++; $display("FAIL after_rst_flag: got %b want 0", rollover_flag); end
    tick();
    checks++;
    if (count_out !== 3'd2) begin errors++; $display("FAIL after_rst_second_count: got %0d want 2", count_out); end
    checks++;
    if (rollover_flag !== 1'b1) begin errors++; $display("FAIL after_rst_second_flag: got %b want 1", rollover_flag); end
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_hold();
    test_clear_priority();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/accumu_counter.md
Name: accumu_counter

Overview:
- Parameterised, synchronously clearable up-counter with a registered rollover flag.
- Used in the Huffman encoder datapath to count accumulated events, for example symbols or bits per group.
- Signals the consumer with rollover_flag when the programmed terminal value is reached.
- Wraps back to 1 on the next enabled cycle after the terminal value, so each terminal period spans ROLLOVER_VAL enabled counts.

Parameters:
- NUM_CNT_BITS, 3, width of count_out in bits (minimum 1).
- ROLLOVER_VAL, 2, terminal count value; legal range 1 .. 2^NUM_CNT_BITS-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- n_rst  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous clear; active high.
- count_enable  input  1  increment request for the current cycle; active high.
- count_out  output  NUM_CNT_BITS  current count, driven directly from a register.
- rollover_flag  output  1  registered; high while count_out equals ROLLOVER_VAL.

Behaviour:
- Reset:
  - n_rst low forces count_out = 0 and rollover_flag = 0 immediately, without waiting for a clock edge.
  - Outputs are held at those values while n_rst stays low, regardless of clear or count_enable.
- Priority at each rising clk edge, with n_rst high:
  - clear = 1: count_out <= 0 and rollover_flag <= 0. Clear overrides count_enable.
  - Else count_enable = 1 and count_out == ROLLOVER_VAL: count_out <= 1 (wrap-around), rollover_flag <= 0 (or 1 if ROLLOVER_VAL == 1).
  - Else count_enable = 1: count_out <= count_out + 1.
  - Else: count_out and rollover_flag hold.
- Flag timing:
  - rollover_flag is registered and computed from next_count == ROLLOVER_VAL.
  - It rises in the same cycle that count_out becomes ROLLOVER_VAL; there is no extra latency.
  - It stays high for as long as count_out holds ROLLOVER_VAL (count_enable low).
- Latency: one clock from count_enable sampled high to the updated count_out.
- Width rule: the increment is computed in NUM_CNT_BITS bits.
- Out-of-range values: if count_out ever exceeds ROLLOVER_VAL (not reachable from reset), it keeps incrementing and wraps naturally at 2^NUM_CNT_BITS back to 0.
- Reset mid-count: an asynchronous n_rst assertion zeroes the state at once. The first enabled edge after release yields count_out = 1.
- Outputs carry no combinational path from any input; both are flop outputs.

Decomposition:
- Shared package (e.g. huff_pkg):
  - default counter width constant CNT_W = 3
  - default rollover constant CNT_ROLLOVER = 2
  - count typedef for reuse by consumers of count_out
- Single flat module, split into two processes:
  - combinational next-state block computing next_count and next_flag
  - one always_ff block with asynchronous reset
- No sub-module required.

Test Plan:
1. Reset: drive n_rst = 0 with count_enable = 0, then again with count_enable = 1 -> count_out = 0, rollover_flag = 0 within 1 ns, without waiting for a clock edge.
2. Count and flag: release n_rst, count_enable = 1, clear = 0:
   - first rising edge -> count_out = 1, flag = 0
   - second edge -> count_out = 2, flag = 1
3. Wrap: continue with count_enable = 1 from count_out = 2 -> count_out = 1, flag = 0; next edge -> 2, flag = 1.
4. Hold: at count_out = 2, drop count_enable for 3 cycles -> count_out stays 2 and flag stays 1 for all cycles.
5. Clear priority: at count_out = 2 with flag = 1, assert clear and count_enable together -> next edge count_out = 0, flag = 0; deassert clear -> next enabled edge gives 1.
6. Async reset mid-count: assert n_rst between clock edges at count_out = 1 -> outputs go to 0 before the next edge; after release, first enabled edge gives 1.
